// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
// Scans a 4x4 active-low matrix keypad one column at a time, debounces
// press and release on a divided scan tick, reports each accepted key as
// a one-hot code with a valid pulse, and builds a three-digit BCD entry
// (clear / backspace / enter) that is committed to the display path.
module keypad_scan_ctrl #(
   parameter int CLK_DIV  = 50000,
   parameter int DEBOUNCE = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  row,
   output logic [3:0]  col,
   output logic [15:0] key_onehot,
   output logic        key_valid,
   output logic [11:0] digits,
   output logic [1:0]  digit_count,
   output logic [11:0] entry,
   output logic        entry_valid
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int DEB_W = $clog2(DEBOUNCE + 1);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DEB_W-1:0] DEB_DONE = DEB_W'(DEBOUNCE);
   localparam logic [DEB_W-1:0] DEB_REL  = DEB_W'(DEBOUNCE - 1);
   localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);

   localparam logic [3:0] KEY_CLEAR = 4'd12;
   localparam logic [3:0] KEY_BKSP  = 4'd4;
   localparam logic [3:0] KEY_ENTER = 4'd0;

   typedef enum logic [1:0] {
      ST_SCAN,
      ST_DEBOUNCE,
      ST_PRESSED,
      ST_RELEASE
   } state_t;

   // True when exactly one of the four active-low lines is asserted.
   function automatic logic single_low(input logic [3:0] v);
      return (v == 4'b1110) || (v == 4'b1101) ||
             (v == 4'b1011) || (v == 4'b0111);
   endfunction

   // Position of the low line in a single-low vector.
   function automatic logic [1:0] low_index(input logic [3:0] v);
      logic [1:0] idx;
      case (v)
         4'b1101: idx = 2'd1;
         4'b1011: idx = 2'd2;
         4'b0111: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

   // Next column in the scan order 1110 -> 1101 -> 1011 -> 0111.
   function automatic logic [3:0] rotate_col(input logic [3:0] v);
      return {v[2:0], v[3]};
   endfunction

   // Key index to {is_digit, bcd value}; non-digit keys return 0.
   function automatic logic [4:0] key_digit(input logic [3:0] k);
      logic [4:0] d;
      case (k)
         4'd3:    d = 5'h10;
         4'd7:    d = 5'h11;
         4'd6:    d = 5'h12;
         4'd5:    d = 5'h13;
         4'd11:   d = 5'h14;
         4'd10:   d = 5'h15;
         4'd9:    d = 5'h16;
         4'd15:   d = 5'h17;
         4'd14:   d = 5'h18;
         4'd13:   d = 5'h19;
         default: d = 5'h00;
      endcase
      return d;
   endfunction

   logic [3:0]       row_meta_p0;
   logic [3:0]       row_s;
   logic [DIV_W-1:0] div_cnt;
   logic             tick;

   state_t           state, state_nxt;
   logic [3:0]       col_nxt;
   logic [3:0]       cap_row, cap_row_nxt;
   logic [1:0]       cap_col, cap_col_nxt;
   logic [DEB_W-1:0] stab_cnt, stab_nxt;

   logic [3:0]       key_idx;
   logic [4:0]       key_dig;

   assign tick    = (div_cnt == DIV_LAST);
   assign key_idx = {cap_col, low_index(cap_row)};
   assign key_dig = key_digit(key_idx);

   // Two-flop synchronizer for the asynchronous row lines.
   always_ff @(posedge clk) begin
      if (rst) begin
         row_meta_p0 <= 4'hF;
         row_s       <= 4'hF;
      end else begin
         row_meta_p0 <= row;
         row_s       <= row_meta_p0;
      end
   end

   // Free-running scan tick divider, active in every FSM state.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt <= '0;
      end else if (tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   // Scan FSM state register together with column drive and debounce state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_SCAN;
         col      <= 4'b1110;
         cap_row  <= 4'hF;
         cap_col  <= 2'd0;
         stab_cnt <= '0;
      end else begin
         state    <= state_nxt;
         col      <= col_nxt;
         cap_row  <= cap_row_nxt;
         cap_col  <= cap_col_nxt;
         stab_cnt <= stab_nxt;
      end
   end

   // Next-state logic: scan, press debounce, single press cycle, release debounce.
   always_comb begin
      state_nxt   = state;
      col_nxt     = col;
      cap_row_nxt = cap_row;
      cap_col_nxt = cap_col;
      stab_nxt    = stab_cnt;
      case (state)
         ST_SCAN: begin
            if (tick) begin
               if (single_low(row_s)) begin
                  // Hold this column while the press is qualified.
                  cap_row_nxt = row_s;
                  cap_col_nxt = low_index(col);
                  stab_nxt    = DEB_ONE;
                  state_nxt   = ST_DEBOUNCE;
               end else begin
                  // Idle or ghosting pattern: keep scanning.
                  col_nxt = rotate_col(col);
               end
            end
         end
         ST_DEBOUNCE: begin
            if (stab_cnt >= DEB_DONE) begin
               state_nxt = ST_PRESSED;
            end else if (tick) begin
               if (row_s == cap_row) begin
                  stab_nxt = stab_cnt + DEB_ONE;
               end else begin
                  stab_nxt  = '0;
                  col_nxt   = rotate_col(col);
                  state_nxt = ST_SCAN;
               end
            end
         end
         ST_PRESSED: begin
            stab_nxt  = '0;
            state_nxt = ST_RELEASE;
         end
         ST_RELEASE: begin
            if (tick) begin
               if (row_s == 4'hF) begin
                  if (stab_cnt >= DEB_REL) begin
                     stab_nxt  = '0;
                     col_nxt   = rotate_col(col);
                     state_nxt = ST_SCAN;
                  end else begin
                     stab_nxt = stab_cnt + DEB_ONE;
                  end
               end else begin
                  // Any bounce back to pressed restarts the release count.
                  stab_nxt = '0;
               end
            end
         end
         default: begin
            state_nxt = ST_SCAN;
         end
      endcase
   end

   // Key report and digit-entry actions, applied once per accepted press.
   always_ff @(posedge clk) begin
      if (rst) begin
         key_onehot  <= '0;
         key_valid   <= 1'b0;
         digits      <= '0;
         digit_count <= '0;
         entry       <= '0;
         entry_valid <= 1'b0;
      end else begin
         key_valid   <= 1'b0;
         entry_valid <= 1'b0;
         if (state == ST_PRESSED) begin
            key_valid  <= 1'b1;
            key_onehot <= 16'd1 << key_idx;
            if (key_dig[4]) begin
               // A full entry silently drops further digits.
               if (digit_count != 2'd3) begin
                  digits      <= {digits[7:0], key_dig[3:0]};
                  digit_count <= digit_count + 2'd1;
               end
            end else if (key_idx == KEY_CLEAR) begin
               digits      <= '0;
               digit_count <= '0;
            end else if (key_idx == KEY_BKSP) begin
               if (digit_count != 2'd0) begin
                  digits      <= {4'h0, digits[11:4]};
                  digit_count <= digit_count - 2'd1;
               end
            end else if (key_idx == KEY_ENTER) begin
               // Enter always commits, even an empty entry.
               entry       <= digits;
               entry_valid <= 1'b1;
               digits      <= '0;
               digit_count <= '0;
            end
         end
      end
   end

   // Structural invariants of the column drive and the valid pulses.
   always_comb begin
      a_col_single_low: assert (rst !== 1'b0 || single_low(col));
   end

   a_key_valid_pulse: assert property (@(posedge clk) disable iff (rst)
      key_valid |=> !key_valid);

   a_entry_valid_pulse: assert property (@(posedge clk) disable iff (rst)
      entry_valid |=> !entry_valid);

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with CLK_DIV=4, DEBOUNCE=3.
// A small keypad model pulls the chosen row low whenever the DUT drives
// the chosen column, or drives a fixed row pattern for bounce/ghost cases.
module tb_keypad_scan_ctrl;

   logic        clk;
   logic        rst;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [15:0] key_onehot;
   logic        key_valid;
   logic [11:0] digits;
   logic [1:0]  digit_count;
   logic [11:0] entry;
   logic        entry_valid;

   int checks;
   int errors;

   logic       key_on;
   logic [1:0] key_c;
   logic [1:0] key_r;
   logic       force_on;
   logic [3:0] force_row;

   keypad_scan_ctrl #(
      .CLK_DIV  (4),
      .DEBOUNCE (3)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .row         (row),
      .col         (col),
      .key_onehot  (key_onehot),
      .key_valid   (key_valid),
      .digits      (digits),
      .digit_count (digit_count),
      .entry       (entry),
      .entry_valid (entry_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Keypad model: a held key shorts its row to its column.
   always_comb begin
      row = 4'hF;
      if (force_on) begin
         row = force_row;
      end else if (key_on && (col[key_c] == 1'b0)) begin
         row[key_r] = 1'b0;
      end
   end

   // Hold a key long enough to be found and debounced, then release it.
   task automatic do_press(input logic [1:0] c, input logic [1:0] r,
                           output int n_valid, output logic [15:0] oh,
                           output int n_entry, output logic [11:0] ent);
      n_valid = 0;
      n_entry = 0;
      oh      = '0;
      ent     = '0;
      key_c   = c;
      key_r   = r;
      key_on  = 1'b1;
      repeat (60) begin
         @(negedge clk);
         if (key_valid) begin n_valid++; oh = key_onehot; end
         if (entry_valid) begin n_entry++; ent = entry; end
      end
      key_on = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (key_valid) begin n_valid++; oh = key_onehot; end
         if (entry_valid) begin n_entry++; ent = entry; end
      end
   endtask

   task automatic test_reset();
      logic [3:0] exp_col;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (col !== 4'b1110) begin errors++; $display("FAIL reset_col got %b want 1110", col); end
      checks++; if (digits !== 12'h000) begin errors++; $display("FAIL reset_digits got %h want 000", digits); end
      checks++; if (digit_count !== 2'd0) begin errors++; $display("FAIL reset_count got %0d want 0", digit_count); end
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_key_valid got %b want 0", key_valid); end
      checks++; if (key_onehot !== 16'h0000) begin errors++; $display("FAIL reset_onehot got %h want 0000", key_onehot); end
      checks++; if (entry !== 12'h000) begin errors++; $display("FAIL reset_entry got %h want 000", entry); end
      checks++; if (entry_valid !== 1'b0) begin errors++; $display("FAIL reset_entry_valid got %b want 0", entry_valid); end
      rst = 1'b0;
      // Column rotates on the 4th edge after reset release, then every 4.
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         case ((k / 4) % 4)
            0:       exp_col = 4'b1110;
            1:       exp_col = 4'b1101;
            2:       exp_col = 4'b1011;
            default: exp_col = 4'b0111;
         endcase
         checks++;
         if (col !== exp_col) begin
            errors++;
            $display("FAIL idle_rotate cycle %0d got %b want %b", k, col, exp_col);
         end
      end
   endtask

   task automatic test_single_press();
      int nv, ne;
      logic [15:0] oh;
      logic [11:0] en;
      do_press(2'd3, 2'd0, nv, oh, ne, en);
      checks++; if (nv != 1) begin errors++; $display("FAIL single_valid_count got %0d want 1", nv); end
      checks++; if (oh !== 16'h1000) begin errors++; $display("FAIL single_onehot got %h want 1000", oh); end
      checks++; if (ne != 0) begin errors++; $display("FAIL single_entry_count got %0d want 0", ne); end
   endtask

   task automatic test_digit_entry();
      int nv, ne;
      logic [15:0] oh;
      logic [11:0] en;
      do_press(2'd1, 2'd3, nv, oh, ne, en);
      checks++; if (digits !== 12'h001 || digit_count !== 2'd1) begin errors++; $display("FAIL digit_1 got %h/%0d want 001/1", digits, digit_count); end
      do_press(2'd1, 2'd2, nv, oh, ne, en);
      checks++; if (digits !== 12'h012 || digit_count !== 2'd2) begin errors++; $display("FAIL digit_2 got %h/%0d want 012/2", digits, digit_count); end
      do_press(2'd1, 2'd1, nv, oh, ne, en);
      checks++; if (digits !== 12'h123 || digit_count !== 2'd3) begin errors++; $display("FAIL digit_3 got %h/%0d want 123/3", digits, digit_count); end
      checks++; if (oh !== 16'h0020) begin errors++; $display("FAIL digit_3_onehot got %h want 0020", oh); end
      do_press(2'd2, 2'd3, nv, oh, ne, en);
      checks++; if (nv != 1) begin errors++; $display("FAIL digit_overflow_valid got %0d want 1", nv); end
      checks++; if (oh !== 16'h0800) begin errors++; $display("FAIL digit_overflow_onehot got %h want 0800", oh); end
      checks++; if (digits !== 12'h123 || digit_count !== 2'd3) begin errors++; $display("FAIL digit_overflow got %h/%0d want 123/3", digits, digit_count); end
      do_press(2'd0, 2'd0, nv, oh, ne, en);
      checks++; if (ne != 1) begin errors++; $display("FAIL enter_pulse_count got %0d want 1", ne); end
      checks++; if (en !== 12'h123) begin errors++; $display("FAIL enter_value_at_pulse got %h want 123", en); end
      checks++; if (entry !== 12'h123) begin errors++; $display("FAIL enter_entry got %h want 123", entry); end
      checks++; if (digits !== 12'h000 || digit_count !== 2'd0) begin errors++; $display("FAIL enter_clears got %h/%0d want 000/0", digits, digit_count); end
   endtask

   task automatic test_backspace();
      int nv, ne;
      logic [15:0] oh;
      logic [11:0] en;
      do_press(2'd3, 2'd1, nv, oh, ne, en);
      do_press(2'd3, 2'd2, nv, oh, ne, en);
      checks++; if (digits !== 12'h098 || digit_count !== 2'd2) begin errors++; $display("FAIL bs_setup got %h/%0d want 098/2", digits, digit_count); end
      do_press(2'd1, 2'd0, nv, oh, ne, en);
      checks++; if (digits !== 12'h009 || digit_count !== 2'd1) begin errors++; $display("FAIL bs_first got %h/%0d want 009/1", digits, digit_count); end
      checks++; if (oh !== 16'h0010) begin errors++; $display("FAIL bs_onehot got %h want 0010", oh); end
      do_press(2'd1, 2'd0, nv, oh, ne, en);
      checks++; if (digits !== 12'h000 || digit_count !== 2'd0) begin errors++; $display("FAIL bs_second got %h/%0d want 000/0", digits, digit_count); end
      do_press(2'd1, 2'd0, nv, oh, ne, en);
      checks++; if (nv != 1) begin errors++; $display("FAIL bs_empty_valid got %0d want 1", nv); end
      checks++; if (digits !== 12'h000 || digit_count !== 2'd0) begin errors++; $display("FAIL bs_underflow got %h/%0d want 000/0", digits, digit_count); end
   endtask

   task automatic test_ignored_clear_enter();
      int nv, ne;
      logic [15:0] oh;
      logic [11:0] en;
      do_press(2'd2, 2'd2, nv, oh, ne, en);
      checks++; if (digits !== 12'h005 || digit_count !== 2'd1) begin errors++; $display("FAIL digit_5 got %h/%0d want 005/1", digits, digit_count); end
      do_press(2'd0, 2'd1, nv, oh, ne, en);
      checks++; if (nv != 1 || oh !== 16'h0002) begin errors++; $display("FAIL ignored_key got %0d/%h want 1/0002", nv, oh); end
      checks++; if (digits !== 12'h005 || digit_count !== 2'd1) begin errors++; $display("FAIL ignored_digits got %h/%0d want 005/1", digits, digit_count); end
      do_press(2'd3, 2'd0, nv, oh, ne, en);
      checks++; if (digits !== 12'h000 || digit_count !== 2'd0) begin errors++; $display("FAIL clear_digits got %h/%0d want 000/0", digits, digit_count); end
      do_press(2'd0, 2'd0, nv, oh, ne, en);
      checks++; if (ne != 1) begin errors++; $display("FAIL empty_enter_pulse got %0d want 1", ne); end
      checks++; if (entry !== 12'h000) begin errors++; $display("FAIL empty_enter_value got %h want 000", entry); end
   endtask

   task automatic test_bounce_and_ghost();
      int nv;
      int changes;
      logic [3:0] prev_col;
      nv = 0;
      force_on = 1'b1;
      for (int i = 0; i < 20; i++) begin
         force_row = (i % 2 == 0) ? 4'b1110 : 4'b1111;
         repeat (4) begin
            @(negedge clk);
            if (key_valid) nv++;
         end
      end
      force_row = 4'b1111;
      repeat (20) begin
         @(negedge clk);
         if (key_valid) nv++;
      end
      checks++; if (nv != 0) begin errors++; $display("FAIL bounce_valid got %0d want 0", nv); end
      nv = 0;
      changes = 0;
      force_row = 4'b1100;
      prev_col = col;
      repeat (40) begin
         @(negedge clk);
         if (key_valid) nv++;
         if (col !== prev_col) changes++;
         prev_col = col;
      end
      checks++; if (nv != 0) begin errors++; $display("FAIL ghost_valid got %0d want 0", nv); end
      checks++; if (changes < 8) begin errors++; $display("FAIL ghost_rotate got %0d changes want at least 8", changes); end
      force_row = 4'b1111;
      force_on  = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_reset_mid_debounce();
      int nv;
      int wait_cnt;
      logic [3:0] prev_col;
      nv = 0;
      wait_cnt = 0;
      prev_col = col;
      // Align to a scan tick by waiting for a column step.
      while (col === prev_col && wait_cnt < 20) begin
         @(negedge clk);
         wait_cnt++;
      end
      checks++; if (col === prev_col) begin errors++; $display("FAIL mid_align got col %b unchanged want a step", col); end
      force_row = 4'b1110;
      force_on  = 1'b1;
      // Two stable ticks land 4 and 8 edges after the step; reset before the third.
      repeat (9) begin
         @(negedge clk);
         if (key_valid) nv++;
      end
      force_row = 4'b1111;
      rst = 1'b1;
      @(negedge clk);
      checks++; if (col !== 4'b1110) begin errors++; $display("FAIL mid_reset_col got %b want 1110", col); end
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_key_valid got %b want 0", key_valid); end
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (key_valid) nv++;
      end
      checks++; if (col !== 4'b1110) begin errors++; $display("FAIL mid_post_hold got %b want 1110", col); end
      @(negedge clk);
      checks++; if (col !== 4'b1101) begin errors++; $display("FAIL mid_post_rotate got %b want 1101", col); end
      repeat (36) begin
         @(negedge clk);
         if (key_valid) nv++;
      end
      force_on = 1'b0;
      checks++; if (nv != 0) begin errors++; $display("FAIL mid_reset_no_key got %0d want 0", nv); end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      key_on    = 1'b0;
      key_c     = 2'd0;
      key_r     = 2'd0;
      force_on  = 1'b0;
      force_row = 4'hF;
      test_reset();
      test_single_press();
      test_digit_entry();
      test_backspace();
      test_ignored_clear_enter();
      test_bounce_and_ghost();
      test_reset_mid_debounce();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
